// File: rtl/fsm_seq_capture.sv
// Step-sequenced capture FSM: start arms a run of NUM_STEPS enable-qualified captures,
// then a one-cycle DONE pulse. Also classifies sel into a registered priority class.
module fsm_seq_capture #(
   parameter int DATA_W    = 8,
   parameter int NUM_STEPS = 4,
   parameter int SEL_W     = 2,
   localparam int CNT_W    = (NUM_STEPS <= 2) ? 1 : $clog2(NUM_STEPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              enable,
   input  logic [DATA_W-1:0] data_in,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  step,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic [1:0]        cls
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

   // Kept as a raw vector so the unused 2'b11 encoding stays representable.
   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [CNT_W-1:0]  r_step;
   logic [CNT_W-1:0]  w_step;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] w_data;
   logic              r_illegal;
   logic              w_ill_set;
   logic [1:0]        r_cls;
   logic [1:0]        w_cls;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_step    <= '0;
         r_data    <= '0;
         r_illegal <= 1'b0;
         r_cls     <= 2'd0;
      end else begin
         r_state   <= w_next;
         r_step    <= w_step;
         r_data    <= w_data;
         r_illegal <= r_illegal | w_ill_set;
         r_cls     <= w_cls;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_step    = r_step;
      w_data    = r_data;
      w_ill_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_next = S_RUN;
               w_step = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               w_next = S_IDLE;
               w_step = '0;
            end else if (enable) begin
               w_data = data_in;
               if (r_step == LAST_STEP) w_next = S_DONE;
               else                     w_step = r_step + CNT_W'(1);
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
            if (abort) w_step = '0;
         end
         default: begin
            w_next    = S_IDLE;
            w_step    = '0;
            w_ill_set = 1'b1;
         end
      endcase
   end

   // First-match priority; with SEL_W=1 the bit-0 test wins, so class 2/3 never occur.
   always_comb begin
      w_cls = 2'd3;
      if (sel == '0)          w_cls = 2'd0;
      else if (sel[0])        w_cls = 2'd1;
      else if (sel[SEL_W-1])  w_cls = 2'd2;
      else                    w_cls = 2'd3;
   end

   assign data_out = r_data;
   assign step     = r_step;
   assign busy     = (r_state == S_RUN);
   assign done     = (r_state == S_DONE);
   assign illegal  = r_illegal;
   assign cls      = r_cls;

endmodule

// File: tb/tb_fsm_seq_capture.sv
// Scoreboard bench for fsm_seq_capture: stimulus queues the expected post-edge outputs,
// a negedge monitor pops and compares them.
module tb_fsm_seq_capture;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, abort = 1'b0, enable = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [1:0] sel = 2'b00;
   logic [7:0] data_out;
   logic [1:0] step;
   logic       busy, done, illegal;
   logic [1:0] cls;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string      nm;
      logic       busy, done, ill;
      logic [1:0] step;
      logic [7:0] data;
      logic [1:0] cls;
   } exp_t;

   exp_t q[$];

   fsm_seq_capture #(.DATA_W(8), .NUM_STEPS(4), .SEL_W(2)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .enable(enable),
      .data_in(data_in), .sel(sel), .data_out(data_out), .step(step),
      .busy(busy), .done(done), .illegal(illegal), .cls(cls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: one expected record per cycle, compared away from the rising edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk({e.nm, ".busy"},    64'(busy),     64'(e.busy));
         chk({e.nm, ".done"},    64'(done),     64'(e.done));
         chk({e.nm, ".illegal"}, 64'(illegal),  64'(e.ill));
         chk({e.nm, ".step"},    64'(step),     64'(e.step));
         chk({e.nm, ".data"},    64'(data_out), 64'(e.data));
         chk({e.nm, ".cls"},     64'(cls),      64'(e.cls));
      end
   end

   task automatic push(input string nm, input logic eb, ed, ei,
                       input logic [1:0] es, input logic [7:0] edat, input logic [1:0] ec);
      exp_t e;
      e.nm = nm; e.busy = eb; e.done = ed; e.ill = ei;
      e.step = es; e.data = edat; e.cls = ec;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
   task automatic cyc(input string nm, input logic st, ab, en, input logic [7:0] d,
                      input logic [1:0] s, input logic eb, ed, ei,
                      input logic [1:0] es, input logic [7:0] edat, input logic [1:0] ec);
      @(negedge clk);
      #1;
      start = st; abort = ab; enable = en; data_in = d; sel = s;
      push(nm, eb, ed, ei, es, edat, ec);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, ".busy"},    64'(busy),     64'(0));
      chk({nm, ".done"},    64'(done),     64'(0));
      chk({nm, ".illegal"}, 64'(illegal),  64'(0));
      chk({nm, ".step"},    64'(step),     64'(0));
      chk({nm, ".data"},    64'(data_out), 64'(0));
      chk({nm, ".cls"},     64'(cls),      64'(0));
   endtask

   initial begin
      #2 chk_reset_vals("reset_init");
      @(negedge clk); #1 rst = 1'b0;

      // full four-step sequence; start during DONE is ignored
      cyc("t1_start", 1,0,0,8'h00,0, 1,0,0, 2'd0,8'h00,0);
      cyc("t1_en1",   0,0,1,8'hA1,0, 1,0,0, 2'd1,8'hA1,0);
      cyc("t1_en2",   0,0,1,8'hA2,0, 1,0,0, 2'd2,8'hA2,0);
      cyc("t1_en3",   0,0,1,8'hA3,0, 1,0,0, 2'd3,8'hA3,0);
      cyc("t1_en4",   0,0,1,8'hA4,0, 0,1,0, 2'd3,8'hA4,0);
      cyc("t1_after", 1,0,0,8'h00,0, 0,0,0, 2'd3,8'hA4,0);

      // enable gaps hold step and data
      cyc("t2_start", 1,0,0,8'h00,0, 1,0,0, 2'd0,8'hA4,0);
      cyc("t2_en1",   0,0,1,8'hB1,0, 1,0,0, 2'd1,8'hB1,0);
      cyc("t2_gap1",  0,0,0,8'hB2,0, 1,0,0, 2'd1,8'hB1,0);
      cyc("t2_gap2",  0,0,0,8'hB3,0, 1,0,0, 2'd1,8'hB1,0);
      cyc("t2_en2",   0,0,1,8'hB4,0, 1,0,0, 2'd2,8'hB4,0);

      // abort at step 2, then abort and start+abort in IDLE
      cyc("t3_abort",    0,1,1,8'hC5,0, 0,0,0, 2'd0,8'hB4,0);
      cyc("t3_idle",     0,0,0,8'h00,0, 0,0,0, 2'd0,8'hB4,0);
      cyc("t3_ab_idle",  0,1,0,8'h00,0, 0,0,0, 2'd0,8'hB4,0);
      cyc("t3_st_ab",    1,1,0,8'h00,0, 0,0,0, 2'd0,8'hB4,0);

      // selector classification
      cyc("t4_sel0", 0,0,0,8'h00,2'b00, 0,0,0, 2'd0,8'hB4,2'd0);
      cyc("t4_sel1", 0,0,0,8'h00,2'b01, 0,0,0, 2'd0,8'hB4,2'd1);
      cyc("t4_sel2", 0,0,0,8'h00,2'b10, 0,0,0, 2'd0,8'hB4,2'd2);
      cyc("t4_sel3", 0,0,0,8'h00,2'b11, 0,0,0, 2'd0,8'hB4,2'd1);

      // unused encoding 11 recovers to IDLE and latches illegal
      @(negedge clk);
      #1;
      start = 0; abort = 0; enable = 0; data_in = 8'h00; sel = 2'b00;
      force dut.r_state = 2'b11;
      #1 release dut.r_state;
      chk("t5_bad.busy", 64'(busy), 64'(0));
      chk("t5_bad.done", 64'(done), 64'(0));
      push("t5_recover", 0,0,1, 2'd0,8'hB4,0);
      cyc("t5_start", 1,0,0,8'h00,0, 1,0,1, 2'd0,8'hB4,0);
      cyc("t5_en1",   0,0,1,8'hD1,0, 1,0,1, 2'd1,8'hD1,0);
      cyc("t5_en2",   0,0,1,8'hD2,0, 1,0,1, 2'd2,8'hD2,0);
      cyc("t5_en3",   0,0,1,8'hD3,0, 1,0,1, 2'd3,8'hD3,0);
      cyc("t5_en4",   0,0,1,8'hD4,0, 0,1,1, 2'd3,8'hD4,0);
      cyc("t5_after", 0,0,0,8'h00,0, 0,0,1, 2'd3,8'hD4,0);

      // asynchronous reset between edges mid-RUN
      cyc("t6_start", 1,0,0,8'h00,0, 1,0,1, 2'd0,8'hD4,0);
      cyc("t6_en1",   0,0,1,8'hE1,0, 1,0,1, 2'd1,8'hE1,0);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_vals("t6_async_rst");
      @(negedge clk);
      #1 rst = 1'b0;
      start = 0; abort = 0; enable = 0; data_in = 8'h00; sel = 2'b00;
      cyc("t6_idle",  0,0,0,8'h00,0, 0,0,0, 2'd0,8'h00,0);
      cyc("t6_start2",1,0,0,8'h00,0, 1,0,0, 2'd0,8'h00,0);

      begin
         int guard;
         guard = 0;
         while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
         end
         #6;
         if (q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fsm_seq_capture.md
FSM_SEQ_CAPTURE -- requirements
Module: fsm_seq_capture

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning capture data width (1..64).
REQ-002 The block SHALL have parameter NUM_STEPS, default 4, meaning run-phase step count (2..256).
REQ-003 The block SHALL have parameter SEL_W, default 2, meaning selector width for priority classification (1..8).
REQ-004 The block SHALL have local constant CNT_W = max(1, clog2(NUM_STEPS)), the step counter width.
REQ-005 The block SHALL have port clk  input  1  clock; single clock domain, all state updates on its rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port start  input  1  begin a sequence; sampled in IDLE only.
REQ-008 The block SHALL have port abort  input  1  terminate any sequence in progress.
REQ-009 The block SHALL have port enable  input  1  advance qualifier and capture strobe in RUN.
REQ-010 The block SHALL have port data_in  input  DATA_W  capture data.
REQ-011 The block SHALL have port sel  input  SEL_W  selector to classify.
REQ-012 The block SHALL have port data_out  output  DATA_W  last captured data, registered.
REQ-013 The block SHALL have port step  output  CNT_W  current step index, registered.
REQ-014 The block SHALL have port busy  output  1  high in RUN.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse on sequence completion.
REQ-016 The block SHALL have port illegal  output  1  sticky flag set when an unused state encoding is detected.
REQ-017 The block SHALL have port cls  output  2  registered priority class of sel.

Function
REQ-018 The FSM SHALL use a 2-bit state register with IDLE=00, RUN=01, DONE=10; encoding 11 is unused.
REQ-019 In IDLE, start=1 SHALL move to RUN with step cleared to 0; start=0 SHALL hold IDLE.
REQ-020 In RUN with enable=1, data_out SHALL load data_in on the same edge; with enable=0, data_out and step SHALL hold (no latches, no combinational path).
REQ-021 In RUN, enable=1 with step<NUM_STEPS-1 SHALL increment step; enable=1 with step==NUM_STEPS-1 SHALL capture, move to DONE, and leave step at NUM_STEPS-1.
REQ-022 DONE SHALL last exactly one cycle, assert done=1 during that cycle, then return to IDLE unconditionally; start in DONE SHALL be ignored.
REQ-023 abort=1 SHALL override all else: next state IDLE, step cleared to 0, data_out held, no done pulse; abort in IDLE SHALL have no effect.
REQ-024 Simultaneous start and abort in IDLE SHALL remain in IDLE.
REQ-025 State encoding 11 SHALL transition to IDLE on the next edge and set illegal=1; illegal SHALL remain set until rst.
REQ-026 Every state and every code of sel SHALL be decoded with a default branch; all combinational outputs SHALL be assigned in every branch.
REQ-027 cls SHALL be registered every cycle with first-match priority: sel==0 -> 0; sel[0]==1 -> 1; sel[SEL_W-1]==1 -> 2; otherwise -> 3.
REQ-028 With SEL_W=1, sel=1 SHALL yield cls=1; cls=2 and cls=3 are unreachable.
REQ-029 busy SHALL be decoded from state (RUN only); done SHALL be decoded from state (DONE only).

Reset
REQ-030 rst=1 SHALL asynchronously force state=IDLE, step=0, data_out=0, cls=0, and illegal=0 so that busy=0 and done=0, regardless of clk.
REQ-031 Reset deassertion SHALL take effect at the next rising clk, with IDLE behaviour from that edge.
REQ-032 rst asserted mid-RUN SHALL discard the sequence immediately without a done pulse.

Verification
REQ-033 The bench SHALL apply NUM_STEPS=4, start, then enable=1 for 4 cycles with data 0xA1..0xA4, and check data_out=0xA4, a done pulse exactly 1 cycle after the 4th enable edge, and busy=0 afterwards.
REQ-034 The bench SHALL apply start, then enable 1,0,0,1 and check that step holds across enable=0 cycles (0,1,1,1,2) and that data_out changes only on enable cycles.
REQ-035 The bench SHALL apply abort at step=2 and check IDLE next cycle, step=0, data_out unchanged, and no done pulse.
REQ-036 The bench SHALL force state=11 for one cycle and check IDLE on the next edge and illegal=1, that illegal stays 1 through a full sequence, and that illegal clears only on rst.
REQ-037 The bench SHALL drive sel=00,01,10,11 (SEL_W=2) and check that cls equals 0,1,2,1 respectively, one cycle later.
REQ-038 The bench SHALL assert rst asynchronously between clk edges mid-RUN and check that all outputs reach reset values before the next edge.
